// File: rtl/input_ctrl_pkg.sv
// Shared types and default sizing for the input buffer array sequencer.
package input_ctrl_pkg;

    localparam int NUM_ROWS      = 32;
    localparam int WORDS_PER_ROW = 7;
    localparam int ELEM_W        = 16;
    localparam int AXI_W         = 32;
    localparam int ELEMS         = 2 * WORDS_PER_ROW;
    localparam int DRAIN_LEN     = ELEMS + NUM_ROWS - 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/input_array_ctrl_skew_gen.sv
// Diagonal read-enable generator: row i is enabled for skew steps i..i+ELEMS-1.
module skew_gen #(
    parameter int NUM_ROWS = input_ctrl_pkg::NUM_ROWS,
    parameter int ELEMS    = input_ctrl_pkg::ELEMS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                stall,
    output logic [NUM_ROWS-1:0] out_en,
    output logic                last
);
    import input_ctrl_pkg::*;

    localparam int DLEN = ELEMS + NUM_ROWS - 1;
    // Upper window bound i+ELEMS reaches DLEN, so size for 0..DLEN.
    localparam int CW   = cnt_w(DLEN + 1);

    logic [CW-1:0] c_q, c_d;

    always_comb begin
        last = enable & ~stall & (c_q == CW'(DLEN - 1));
        c_d  = c_q;
        if (!enable || last) begin
            c_d = '0;
        end else if (!stall) begin
            c_d = c_q + 1'b1;
        end
        out_en = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            out_en[i] = enable & ~stall
                      & (c_q >= CW'(i))
                      & (c_q <  CW'(i + ELEMS));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q <= '0;
        end else begin
            c_q <= c_d;
        end
    end

endmodule

// File: rtl/input_array_ctrl.sv
// Tile sequencer: routes AXI words to row buffers, then drains them diagonally.
module input_array_ctrl #(
    parameter int NUM_ROWS      = input_ctrl_pkg::NUM_ROWS,
    parameter int WORDS_PER_ROW = input_ctrl_pkg::WORDS_PER_ROW,
    parameter int ELEM_W        = input_ctrl_pkg::ELEM_W,
    parameter int AXI_W         = input_ctrl_pkg::AXI_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [AXI_W-1:0]    s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic [AXI_W-1:0]    row_data,
    output logic [NUM_ROWS-1:0] fifo_en,
    output logic [NUM_ROWS-1:0] out_en,
    input  logic                out_stall,
    output logic                busy,
    output logic                tile_done
);
    import input_ctrl_pkg::*;

    localparam int ELEMS = (AXI_W / ELEM_W) * WORDS_PER_ROW;
    localparam int WW    = cnt_w(WORDS_PER_ROW);
    localparam int RW    = cnt_w(NUM_ROWS);

    state_e              state_q, state_d;
    logic [WW-1:0]       word_cnt_q, word_cnt_d;
    logic [RW-1:0]       row_cnt_q, row_cnt_d;
    logic [AXI_W-1:0]    row_data_q, row_data_d;
    logic [NUM_ROWS-1:0] fifo_en_q, fifo_en_d;
    logic                xfer, last_word, last_row;
    logic                drain_en, drain_last;

    assign s_ready   = (state_q == LOAD);
    assign busy      = (state_q == LOAD) | (state_q == DRAIN);
    assign tile_done = (state_q == DONE);
    assign drain_en  = (state_q == DRAIN);
    assign row_data  = row_data_q;
    assign fifo_en   = fifo_en_q;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        row_cnt_d  = row_cnt_q;
        row_data_d = row_data_q;
        fifo_en_d  = '0;
        xfer       = s_valid & s_ready;
        last_word  = (word_cnt_q == WW'(WORDS_PER_ROW - 1));
        last_row   = (row_cnt_q == RW'(NUM_ROWS - 1));
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    word_cnt_d = '0;
                    row_cnt_d  = '0;
                end
            end
            LOAD: begin
                if (xfer) begin
                    row_data_d = s_data;
                    fifo_en_d  = NUM_ROWS'(1) << row_cnt_q;
                    if (last_word) begin
                        word_cnt_d = '0;
                        row_cnt_d  = row_cnt_q + 1'b1;
                        if (last_row) begin
                            state_d   = DRAIN;
                            row_cnt_d = '0;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_last) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            row_cnt_q  <= '0;
            row_data_q <= '0;
            fifo_en_q  <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            row_cnt_q  <= row_cnt_d;
            row_data_q <= row_data_d;
            fifo_en_q  <= fifo_en_d;
        end
    end

    skew_gen #(
        .NUM_ROWS (NUM_ROWS),
        .ELEMS    (ELEMS)
    ) u_skew (
        .clk    (clk),
        .rst    (rst),
        .enable (drain_en),
        .stall  (out_stall),
        .out_en (out_en),
        .last   (drain_last)
    );

endmodule

// File: tb/tb_input_array_ctrl.sv
// Self-checking bench for input_array_ctrl: load routing, diagonal drain, stalls, reset abort.
module tb_input_array_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] row_data;
    logic [31:0] fifo_en;
    logic [31:0] out_en;
    logic        out_stall;
    logic        busy;
    logic        tile_done;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        stall;
        logic [31:0] en;
    } vec_t;

    vec_t tbl[16];

    always #5 clk = ~clk;

    input_array_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .row_data  (row_data),
        .fifo_en   (fifo_en),
        .out_en    (out_en),
        .out_stall (out_stall),
        .busy      (busy),
        .tile_done (tile_done)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Rows whose 14-element window covers skew step c: rows c-13..c.
    function automatic logic [31:0] win(input int c);
        logic [31:0] m;
        m = '0;
        for (int r = c - 13; r <= c; r++)
            if (r >= 0 && r < 32) m[r] = 1'b1;
        return m;
    endfunction

    task automatic run_tile(input int gap_pct, input bit use_tbl,
                            input bit poke, input logic [31:0] salt);
        int          k, pk, guard, j, c, nst, pulses, bad;
        int          rowcnt[32];
        bit          pend, fin;
        logic [31:0] pd, d, exp;
        pk = 0;
        pd = '0;
        @(posedge clk); #1;
        start = 1'b1; s_valid = 1'b1; s_data = 32'hDEAD_BEEF; out_stall = 1'b0;
        @(negedge clk);
        chk("idle_s_ready", s_ready, 0);
        chk("idle_busy", busy, 0);
        chk("idle_done", tile_done, 0);
        k = 0; pend = 0; guard = 0; pulses = 0;
        while (k < 224 && guard < 4000) begin
            guard++;
            @(posedge clk); #1;
            start     = 1'b0;
            s_valid   = ($urandom_range(99) >= gap_pct);
            d         = salt ^ 32'(k);
            s_data    = s_valid ? d : $urandom;
            out_stall = 1'($urandom);
            @(negedge clk);
            chk("load_s_ready", s_ready, 1);
            chk("load_busy", busy, 1);
            chk("load_out_en", out_en, 0);
            chk("load_fifo_en", fifo_en,
                pend ? 64'(32'h1 << (pk / 7)) : 64'd0);
            if (pend) chk("load_row_data", row_data, pd);
            if (fifo_en != 0) pulses++;
            pend = s_valid;
            if (s_valid) begin
                pk = k; pd = d; k++;
            end
        end
        chk("load_words", k, 224);
        for (int i = 0; i < 32; i++) rowcnt[i] = 0;
        c = 0; nst = 0; j = 0; fin = 0;
        while (!fin && j < 200) begin
            @(posedge clk); #1;
            s_valid   = 1'($urandom);
            s_data    = $urandom;
            start     = poke && (j == 5);
            out_stall = (use_tbl && j < 16) ? tbl[j].stall : 1'b0;
            @(negedge clk);
            exp = (use_tbl && j < 16) ? tbl[j].en
                : (out_stall ? 32'h0 : win(c));
            chk("drain_out_en", out_en, exp);
            chk("drain_s_ready", s_ready, 0);
            chk("drain_busy", busy, 1);
            chk("drain_done", tile_done, 0);
            chk("drain_fifo_en", fifo_en, (j == 0) ? 32'h8000_0000 : 32'h0);
            if (j == 0) chk("last_row_data", row_data, pd);
            if (fifo_en != 0) pulses++;
            for (int i = 0; i < 32; i++) if (out_en[i]) rowcnt[i]++;
            if (out_stall) nst++;
            else begin
                if (c == 44) fin = 1;
                c++;
            end
            j++;
        end
        chk("drain_len", j, 45 + nst);
        chk("fifo_pulses", pulses, 224);
        bad = 0;
        for (int i = 0; i < 32; i++) if (rowcnt[i] != 14) bad++;
        chk("row_en_count_bad_rows", bad, 0);
        @(posedge clk); #1;
        start = poke; s_valid = 1'b1; out_stall = 1'($urandom);
        @(negedge clk);
        chk("done_pulse", tile_done, 1);
        chk("done_busy", busy, 0);
        chk("done_s_ready", s_ready, 0);
        chk("done_out_en", out_en, 0);
        chk("done_fifo_en", fifo_en, 0);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 32'h0000_0001};
        tbl[1]  = '{1'b0, 32'h0000_0003};
        tbl[2]  = '{1'b0, 32'h0000_0007};
        tbl[3]  = '{1'b0, 32'h0000_000F};
        tbl[4]  = '{1'b0, 32'h0000_001F};
        tbl[5]  = '{1'b0, 32'h0000_003F};
        tbl[6]  = '{1'b0, 32'h0000_007F};
        tbl[7]  = '{1'b0, 32'h0000_00FF};
        tbl[8]  = '{1'b0, 32'h0000_01FF};
        tbl[9]  = '{1'b0, 32'h0000_03FF};
        tbl[10] = '{1'b1, 32'h0000_0000};
        tbl[11] = '{1'b1, 32'h0000_0000};
        tbl[12] = '{1'b1, 32'h0000_0000};
        tbl[13] = '{1'b0, 32'h0000_07FF};
        tbl[14] = '{1'b0, 32'h0000_0FFF};
        tbl[15] = '{1'b0, 32'h0000_1FFF};

        rst = 1'b1; start = 1'b0; s_valid = 1'b0;
        s_data = '0; out_stall = 1'b0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_fifo_en", fifo_en, 0);
        chk("rst_out_en", out_en, 0);
        chk("rst_row_data", row_data, 0);
        chk("rst_done", tile_done, 0);
        @(posedge clk); #1 rst = 1'b0;

        run_tile(0, 1'b0, 1'b0, 32'h0);
        run_tile(30, 1'b0, 1'b0, $urandom);
        run_tile(0, 1'b1, 1'b1, $urandom);
        run_tile(20, 1'b0, 1'b0, $urandom);

        @(posedge clk); #1;
        start = 1'b1; s_valid = 1'b1; s_data = 32'h0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            s_data = s_data + 1;
        end
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_s_ready", s_ready, 0);
        chk("abort_fifo_en", fifo_en, 0);
        chk("abort_out_en", out_en, 0);
        chk("abort_row_data", row_data, 0);
        chk("abort_done", tile_done, 0);
        @(posedge clk); #1;
        rst = 1'b0; s_valid = 1'b0;
        run_tile(30, 1'b0, 1'b0, $urandom);

        @(posedge clk); #1;
        start = 1'b0; s_valid = 1'b1;
        @(negedge clk);
        chk("final_idle_busy", busy, 0);
        chk("final_idle_done", tile_done, 0);
        chk("final_idle_s_ready", s_ready, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
